// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the signals between the pipeline datapath and the
// sequencing controller.
//   master modport: pipeline side. It drives the hazard inputs (*_i) and
//                   receives the control outputs (*_o).
//   slave modport : controller side (hazard_ctrl).
// Signals:
//   fd_rs1_i/fd_rs2_i                      decode-stage source registers
//   de_rs1_i/de_rs2_i, de_rf_we_i,
//   de_mem2rf_i, de_rf_waddr_i             execute-stage sources/destination
//   em_rf_we_i, em_mem2rf_i, em_mem_req_i,
//   em_rf_waddr_i                          memory-stage destination/access
//   mw_rf_we_i, mw_rf_waddr_i              writeback-stage destination
//   br_taken_i, dmem_ack_i                 branch resolved taken / dmem done
//   pc/fd/de/em/mw_en_o                    latch enables
//   fd/de/mw_flush_o                       bubble loads
//   fwd_a_o/fwd_b_o                        execute operand source selects
//   dmem_req_o, mem_err_o, state_o         request, sticky timeout, FSM state
//   stall_cnt_o/flush_cnt_o                performance counters
interface hazard_ctrl_if;
  logic [4:0]  fd_rs1_i;
  logic [4:0]  fd_rs2_i;
  logic [4:0]  de_rs1_i;
  logic [4:0]  de_rs2_i;
  logic        de_rf_we_i;
  logic        de_mem2rf_i;
  logic [4:0]  de_rf_waddr_i;
  logic        em_rf_we_i;
  logic        em_mem2rf_i;
  logic        em_mem_req_i;
  logic [4:0]  em_rf_waddr_i;
  logic        mw_rf_we_i;
  logic [4:0]  mw_rf_waddr_i;
  logic        br_taken_i;
  logic        dmem_ack_i;

  logic        pc_en_o;
  logic        fd_en_o;
  logic        de_en_o;
  logic        em_en_o;
  logic        mw_en_o;
  logic        fd_flush_o;
  logic        de_flush_o;
  logic        mw_flush_o;
  logic [1:0]  fwd_a_o;
  logic [1:0]  fwd_b_o;
  logic        dmem_req_o;
  logic        mem_err_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  modport master (
    output fd_rs1_i, fd_rs2_i, de_rs1_i, de_rs2_i, de_rf_we_i, de_mem2rf_i,
           de_rf_waddr_i, em_rf_we_i, em_mem2rf_i, em_mem_req_i, em_rf_waddr_i,
           mw_rf_we_i, mw_rf_waddr_i, br_taken_i, dmem_ack_i,
    input  pc_en_o, fd_en_o, de_en_o, em_en_o, mw_en_o, fd_flush_o, de_flush_o,
           mw_flush_o, fwd_a_o, fwd_b_o, dmem_req_o, mem_err_o, state_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  fd_rs1_i, fd_rs2_i, de_rs1_i, de_rs2_i, de_rf_we_i, de_mem2rf_i,
           de_rf_waddr_i, em_rf_we_i, em_mem2rf_i, em_mem_req_i, em_rf_waddr_i,
           mw_rf_we_i, mw_rf_waddr_i, br_taken_i, dmem_ack_i,
    output pc_en_o, fd_en_o, de_en_o, em_en_o, mw_en_o, fd_flush_o, de_flush_o,
           mw_flush_o, fwd_a_o, fwd_b_o, dmem_req_o, mem_err_o, state_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the five-stage RV32 core.
// Drives latch enables/flushes and the PC enable, detects load-use hazards,
// selects execute-stage operand forwarding, runs the data-memory
// request/ack handshake with a timeout, and counts stall/flush cycles.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   hc   hazard_ctrl_if.slave (all pipeline inputs and control outputs)
// Parameters:
//   RST_FLUSH_CYCLES  cycles held flushed after reset release (1..15)
//   MEM_TIMEOUT       wait cycles before an unacknowledged access aborts (1..255)
module hazard_ctrl #(
  parameter int unsigned RST_FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT      = 255
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hc
);

  typedef enum logic [1:0] {
    StInit    = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2
  } state_e;

  localparam logic [3:0] InitCycles = 4'(RST_FLUSH_CYCLES);
  localparam logic [7:0] TimeoutCycles = 8'(MEM_TIMEOUT);

  state_e      r_state, w_state_next;
  logic [3:0]  r_init_cnt, w_init_cnt_next;
  logic [7:0]  r_wait_cnt, w_wait_cnt_next;
  logic        r_mem_err, w_mem_err_next;
  logic [31:0] r_stall_cnt, r_flush_cnt;

  logic w_load_use, w_mem_stall;
  logic w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en;
  logic w_fd_flush, w_de_flush, w_mw_flush;
  logic w_dmem_req;
  logic w_active;

  // Forwarding select for one execute operand; EM wins over MW. A load in EM
  // has no data yet, so it is never an EM forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (hc.em_rf_we_i && !hc.em_mem2rf_i && (hc.em_rf_waddr_i != 5'd0) &&
        (hc.em_rf_waddr_i == rs)) begin
      return 2'b01;
    end else if (hc.mw_rf_we_i && (hc.mw_rf_waddr_i != 5'd0) &&
                 (hc.mw_rf_waddr_i == rs)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  assign w_load_use = hc.de_mem2rf_i && hc.de_rf_we_i && (hc.de_rf_waddr_i != 5'd0) &&
                      ((hc.de_rf_waddr_i == hc.fd_rs1_i) ||
                       (hc.de_rf_waddr_i == hc.fd_rs2_i));
  // A same-cycle ack completes the access without stalling.
  assign w_mem_stall = hc.em_mem_req_i && !hc.dmem_ack_i;

  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    w_wait_cnt_next = r_wait_cnt;
    w_mem_err_next  = r_mem_err;
    w_pc_en         = 1'b0;
    w_fd_en         = 1'b0;
    w_de_en         = 1'b0;
    w_em_en         = 1'b0;
    w_mw_en         = 1'b0;
    w_fd_flush      = 1'b1;
    w_de_flush      = 1'b1;
    w_mw_flush      = 1'b1;
    w_dmem_req      = 1'b0;

    unique case (r_state)
      StInit: begin
        if (r_init_cnt <= 4'd1) begin
          w_state_next = StRun;
        end else begin
          w_init_cnt_next = r_init_cnt - 4'd1;
        end
      end

      StRun: begin
        w_dmem_req = hc.em_mem_req_i;
        w_fd_flush = 1'b0;
        w_de_flush = 1'b0;
        w_mw_flush = 1'b0;
        if (w_mem_stall) begin
          // Freeze everything; branch/load-use get re-evaluated on resume.
          w_mw_flush      = 1'b1;
          w_wait_cnt_next = 8'd1;
          w_state_next    = StMemWait;
        end else if (hc.br_taken_i) begin
          {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b11111;
          w_fd_flush = 1'b1;
          w_de_flush = 1'b1;
        end else if (w_load_use) begin
          {w_de_en, w_em_en, w_mw_en} = 3'b111;
          w_de_flush = 1'b1;
        end else begin
          {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b11111;
        end
      end

      StMemWait: begin
        w_dmem_req = hc.em_mem_req_i;
        w_fd_flush = 1'b0;
        w_de_flush = 1'b0;
        if (hc.dmem_ack_i) begin
          {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b11111;
          w_mw_flush   = 1'b0;
          w_state_next = StRun;
        end else if (r_wait_cnt >= TimeoutCycles) begin
          // Abort: let the memory-stage op drain into a bubble in MW.
          w_em_en        = 1'b1;
          w_mw_en        = 1'b1;
          w_mem_err_next = 1'b1;
          w_state_next   = StRun;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 8'd1;
        end
      end

      default: begin
        w_state_next    = StInit;
        w_init_cnt_next = InitCycles;
      end
    endcase
  end

  assign w_active = (r_state == StRun) || (r_state == StMemWait);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StInit;
      r_init_cnt  <= InitCycles;
      r_wait_cnt  <= 8'd0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_mem_err  <= w_mem_err_next;
      if (w_active && !w_pc_en) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_active && (w_fd_flush || w_de_flush)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign hc.pc_en_o     = w_pc_en;
  assign hc.fd_en_o     = w_fd_en;
  assign hc.de_en_o     = w_de_en;
  assign hc.em_en_o     = w_em_en;
  assign hc.mw_en_o     = w_mw_en;
  assign hc.fd_flush_o  = w_fd_flush;
  assign hc.de_flush_o  = w_de_flush;
  assign hc.mw_flush_o  = w_mw_flush;
  assign hc.fwd_a_o     = fwd_sel(hc.de_rs1_i);
  assign hc.fwd_b_o     = fwd_sel(hc.de_rs2_i);
  assign hc.dmem_req_o  = w_dmem_req;
  assign hc.mem_err_o   = r_mem_err;
  assign hc.state_o     = r_state;
  assign hc.stall_cnt_o = r_stall_cnt;
  assign hc.flush_cnt_o = r_flush_cnt;

endmodule
